// File: rtl/non_overlap_pkg.sv
// Shared types and drive encodings for the clocked break-before-make switch driver.
package non_overlap_pkg;

  localparam int DEAD_W_DEF = 4;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_DEAD = 2'd1,
    CH_LOW  = 2'd2,
    CH_HIGH = 2'd3
  } chan_state_e;

  // {ON, ON_N}; both switches open is the only safe idle state for the mirror
  localparam logic [1:0] DRV_LOW  = 2'b01;
  localparam logic [1:0] DRV_HIGH = 2'b10;
  localparam logic [1:0] DRV_OPEN = 2'b11;

  function automatic logic [1:0] drive_of(chan_state_e s);
    unique case (s)
      CH_LOW:  return DRV_LOW;
      CH_HIGH: return DRV_HIGH;
      default: return DRV_OPEN;
    endcase
  endfunction

endpackage

// File: rtl/non_overlap_chan.sv
// One thermometer channel: OFF/DEAD/LOW/HIGH FSM with a counted dead interval
// and registered ON/ON_N drive.
module non_overlap_chan
  import non_overlap_pkg::*;
#(
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DEAD_W-1:0] dead_cycles,
  input  logic              thermo_bit,
  output logic              on,
  output logic              on_n,
  output logic              dead_nxt
);

  localparam logic [DEAD_W-1:0] CNT_ONE = DEAD_W'(1);

  chan_state_e       state, state_nxt;
  logic [DEAD_W-1:0] cnt, cnt_nxt;
  logic              tgt, tgt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    if (!en) begin
      state_nxt = CH_OFF;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        CH_OFF: begin
          state_nxt = CH_DEAD;
          cnt_nxt   = dead_cycles;
          tgt_nxt   = thermo_bit;
        end
        CH_LOW, CH_HIGH: begin
          if (thermo_bit != (state == CH_HIGH)) begin
            state_nxt = CH_DEAD;
            cnt_nxt   = dead_cycles;
            tgt_nxt   = thermo_bit;
          end
        end
        CH_DEAD: begin
          // latest thermo value wins, so a pulse that reverts lands back where it began
          tgt_nxt = thermo_bit;
          if (cnt == '0) state_nxt = thermo_bit ? CH_HIGH : CH_LOW;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        default: state_nxt = CH_OFF;
      endcase
    end
  end

  assign dead_nxt = (state_nxt == CH_DEAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CH_OFF;
      cnt        <= '0;
      tgt        <= 1'b0;
      {on, on_n} <= DRV_OPEN;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tgt        <= tgt_nxt;
      {on, on_n} <= drive_of(state_nxt);
    end
  end

endmodule

// File: rtl/sync_non_overlap.sv
// Multi-channel clocked non-overlap generator between the thermometer decoder
// and the current-mirror switch array.
module sync_non_overlap
  import non_overlap_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int DEAD_W   = DEAD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DEAD_W-1:0]   dead_cycles,
  input  logic [IN_WIDTH-1:0] thermo,
  output logic [IN_WIDTH-1:0] ON,
  output logic [IN_WIDTH-1:0] ON_N,
  output logic                busy
);

  logic [IN_WIDTH-1:0] dead_nxt;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_chan
    non_overlap_chan #(.DEAD_W(DEAD_W)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .dead_cycles (dead_cycles),
      .thermo_bit  (thermo[i]),
      .on          (ON[i]),
      .on_n        (ON_N[i]),
      .dead_nxt    (dead_nxt[i])
    );
  end

  // registered from next-state so busy lines up with the channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= |dead_nxt;
  end

endmodule

// File: tb/tb_sync_non_overlap.sv
// Self-checking bench: per-channel "dead cycles remaining / settled level" model.
module tb_sync_non_overlap;
  localparam int W  = 32;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] dead_cycles = '0;
  logic [W-1:0]  thermo = '0;
  logic [W-1:0]  ON, ON_N;
  logic          busy;

  int errors = 0;
  int checks = 0;

  sync_non_overlap #(.IN_WIDTH(W), .DEAD_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .dead_cycles(dead_cycles),
    .thermo(thermo), .ON(ON), .ON_N(ON_N), .busy(busy)
  );

  always #5 clk = ~clk;

  // rem = dead cycles still to be shown (0 = not dead); lvl = -1 off, else settled level
  int rem [W];
  int lvl [W];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin rem[i] <= 0; lvl[i] <= -1; end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!en) begin
          rem[i] <= 0; lvl[i] <= -1;
        end else if (rem[i] > 0) begin
          if (rem[i] == 1) begin rem[i] <= 0; lvl[i] <= int'(thermo[i]); end
          else rem[i] <= rem[i] - 1;
        end else if (lvl[i] != int'(thermo[i])) begin
          rem[i] <= int'(dead_cycles) + 1;
        end
      end
    end
  end

  logic [W-1:0] exp_on, exp_on_n;
  logic         exp_busy;
  always_comb begin
    exp_on = '1; exp_on_n = '1; exp_busy = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (rem[i] > 0) exp_busy = 1'b1;
      if (rem[i] == 0 && lvl[i] == 1) exp_on_n[i] = 1'b0;
      if (rem[i] == 0 && lvl[i] == 0) exp_on[i] = 1'b0;
    end
  end

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({ON, ON_N, busy} !== {{W{1'b1}}, {W{1'b1}}, 1'b0}) begin
      errors++;
      $display("FAIL reset: got ON=%h ON_N=%h busy=%b want all ones, busy=0", ON, ON_N, busy);
    end
  endtask

  task automatic test_startup;
    logic [W-1:0] w_on;
    logic w_b;
    rst = 1'b0; en = 1'b1; thermo = '0; dead_cycles = 4'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      w_on = (k <= 4) ? '1 : '0;
      w_b  = (k <= 4);
      checks++;
      if ({ON, ON_N, busy} !== {w_on, {W{1'b1}}, w_b} ||
          {ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy}) begin
        errors++;
        $display("FAIL startup k=%0d: got ON=%h ON_N=%h busy=%b want ON=%h ON_N=%h busy=%b",
                 k, ON, ON_N, busy, w_on, {W{1'b1}}, w_b);
      end
    end
  endtask

  task automatic test_rise;
    logic [1:0] w0;
    thermo[0] = 1'b1; dead_cycles = 4'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      w0 = (k <= 4) ? 2'b11 : 2'b10;
      checks++;
      if ({ON[0], ON_N[0]} !== w0 || ON[W-1:1] !== '0 || ON_N[W-1:1] !== '1 ||
          {ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy}) begin
        errors++;
        $display("FAIL rise k=%0d: got ON=%h ON_N=%h busy=%b want ch0=%b others LOW",
                 k, ON, ON_N, busy, w0);
      end
      if (k == 2) dead_cycles = 4'd9;  // must not affect the running count
    end
  endtask

  task automatic test_d0_toggle;
    int dead5 = 0;
    dead_cycles = 4'd0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (ON[5] && ON_N[5]) dead5++;
      checks++;
      if ({ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy} || (~ON & ~ON_N) !== '0) begin
        errors++;
        $display("FAIL d0_toggle c=%0d: got ON=%h ON_N=%h busy=%b want ON=%h ON_N=%h busy=%b",
                 c, ON, ON_N, busy, exp_on, exp_on_n, exp_busy);
      end
      if (c % 4 == 0) thermo[5] = ~thermo[5];
    end
    checks++;
    if (dead5 !== 6) begin
      errors++;
      $display("FAIL d0_dead_count: got %0d dead cycles want 6", dead5);
    end
  endtask

  task automatic test_glitch;
    int dead2 = 0;
    logic [1:0] w2;
    dead_cycles = 4'd5; thermo[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ON[2] && ON_N[2]) dead2++;
      w2 = (k <= 6) ? 2'b11 : 2'b01;
      checks++;
      if ({ON[2], ON_N[2]} !== w2 || {ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy}) begin
        errors++;
        $display("FAIL glitch k=%0d: got ch2=%b%b busy=%b want ch2=%b", k, ON[2], ON_N[2], busy, w2);
      end
      if (k == 2) thermo[2] = 1'b0;
    end
    checks++;
    if (dead2 !== 6) begin
      errors++;
      $display("FAIL glitch_dead_count: got %0d want 6", dead2);
    end
  endtask

  task automatic test_en_drop;
    logic [W-1:0] w_on, w_n;
    logic w_b;
    thermo = '1; dead_cycles = 4'd2;
    repeat (4) @(negedge clk);
    checks++;
    if (ON !== '1 || ON_N !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_pre: got ON=%h ON_N=%h busy=%b want all HIGH", ON, ON_N, busy);
    end
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      w_on = '1;
      w_n  = (k == 5) ? '0 : '1;
      w_b  = (k >= 2 && k <= 4);
      checks++;
      if ({ON, ON_N, busy} !== {w_on, w_n, w_b} ||
          {ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy}) begin
        errors++;
        $display("FAIL en_drop k=%0d: got ON=%h ON_N=%h busy=%b want ON=%h ON_N=%h busy=%b",
                 k, ON, ON_N, busy, w_on, w_n, w_b);
      end
      en = 1'b1;
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] w_on;
    logic w_b;
    thermo = '0; dead_cycles = 4'd7;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got busy=%b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ON, ON_N, busy} !== {{W{1'b1}}, {W{1'b1}}, 1'b0} ||
        {ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy}) begin
      errors++;
      $display("FAIL reset_mid_async: got ON=%h ON_N=%h busy=%b want all ones, busy=0", ON, ON_N, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      w_on = (k <= 8) ? '1 : '0;
      w_b  = (k <= 8);
      checks++;
      if ({ON, ON_N, busy} !== {w_on, {W{1'b1}}, w_b} ||
          {ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy}) begin
        errors++;
        $display("FAIL reset_mid k=%0d: got ON=%h ON_N=%h busy=%b want ON=%h busy=%b",
                 k, ON, ON_N, busy, w_on, w_b);
      end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if ({ON, ON_N, busy} !== {exp_on, exp_on_n, exp_busy} || (~ON & ~ON_N) !== '0) begin
        errors++;
        $display("FAIL random c=%0d: got ON=%h ON_N=%h busy=%b want ON=%h ON_N=%h busy=%b",
                 c, ON, ON_N, busy, exp_on, exp_on_n, exp_busy);
      end
      thermo = thermo ^ ($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 7) == 0) dead_cycles = DW'($urandom_range(0, 15));
      en = ($urandom_range(0, 49) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_rise();
    test_d0_toggle();
    test_glitch();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_non_overlap.md
Name: sync_non_overlap

Overview:
- Clocked, multi-channel successor to the delay-cell non-overlap generator for the current-mirror array.
- Per thermometer bit, drives the ON / ON_N switch pair with break-before-make. Dead time is a counted number of clock cycles, programmable at run time, instead of a fixed delay-cell chain.
- Adds a global enable that forces every switch off. Sits between the thermometer decoder and the current-mirror switch array.

Parameters:
- IN_WIDTH, 32, number of thermometer channels (one ON/ON_N pair each).
- DEAD_W, 4, width of the dead-time programming field and the per-channel counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = normal operation; 0 = force all channels to OFF.
- dead_cycles  input  DEAD_W  dead-time length D; dead interval lasts D+1 clock cycles.
- thermo  input  IN_WIDTH  thermometer code, synchronous to clk.
- ON  output  IN_WIDTH  per-channel switch drive, registered.
- ON_N  output  IN_WIDTH  per-channel complementary drive, registered.
- busy  output  1  1 while any channel is in DEAD, registered.

Behaviour:
- Output encoding per channel, matching the existing mirror switches:
  - LOW: ON=0, ON_N=1.
  - HIGH: ON=1, ON_N=0.
  - DEAD and OFF: ON=1, ON_N=1 (both switches open).
  - ON=0 with ON_N=0 is never produced.
- Each channel runs a 4-state FSM: OFF, DEAD, LOW, HIGH. It holds a DEAD_W-bit down-counter and a 1-bit target.
- Reset (asynchronous, any time):
  - All channels go to OFF, counters to 0, targets to 0.
  - ON = all ones, ON_N = all ones, busy = 0.
  - Reset mid-dead-time aborts the count immediately.
- OFF:
  - If en=1 at an edge: go to DEAD, counter <= dead_cycles, target <= thermo[i].
  - Otherwise stay in OFF.
- LOW or HIGH with en=1:
  - If thermo[i] differs from the current state at an edge: go to DEAD, counter <= dead_cycles, target <= thermo[i].
  - Otherwise hold.
- DEAD with en=1:
  - Every edge: target <= thermo[i], so the latest value wins when thermo toggles back during dead time.
  - If counter==0: go to HIGH if the new target is 1, else LOW.
  - Otherwise counter decrements.
- Dead-time rules:
  - Dead interval is exactly D+1 cycles. D=0 gives 1 cycle, so a direct LOW<->HIGH swap never occurs.
  - dead_cycles is sampled only on entry to DEAD. Changes mid-count do not affect a running count.
- A thermo pulse that returns to the original value during DEAD:
  - Channel still completes the full D+1 dead cycles.
  - Channel then returns to the original state. No extra dead interval is inserted.
- Latency:
  - thermo change sampled at edge t → both outputs high after edge t.
  - New level after edge t+D+1.
- en=0 at any edge:
  - All channels go to OFF regardless of state, and counters clear.
  - On en returning to 1, every channel passes through a full DEAD interval before driving LOW/HIGH.
- Channels are fully independent; simultaneous transitions on many bits are allowed.
- busy = OR over channels of (state==DEAD), registered with the state.

Decomposition:
- Package non_overlap_pkg:
  - Channel state enum (OFF, DEAD, LOW, HIGH).
  - Output encoding constants: LOW=2'b01 and HIGH=2'b10 as {ON,ON_N}; DEAD/OFF = 2'b11.
  - Default DEAD_W.
- Sub-module non_overlap_chan: one channel FSM, counter and registered ON/ON_N. The top instantiates IN_WIDTH copies in a generate loop and ORs their dead flags into busy.

Test Plan:
- Reset, then release with en=1, thermo=0, dead_cycles=3 → ON=1,ON_N=1 for 4 cycles, then ON=0,ON_N=1; busy high for exactly those 4 cycles.
- thermo[0] 0→1 at edge t, dead_cycles=3 → ch0 outputs 11 at edges t..t+3, HIGH (ON=1,ON_N=0) from t+4; other channels unchanged.
- dead_cycles=0 with thermo[5] toggling every 4 cycles → exactly one dead cycle per toggle; ON_N=0 with ON=0 never observed (assert on all bits, all cycles).
- thermo[2] 0→1 then back to 0 two cycles later, dead_cycles=5 → 6 dead cycles, then LOW; no second dead interval.
- en dropped for 1 cycle while all channels HIGH, dead_cycles=2 → all outputs 11 next edge, then 3 dead cycles after en=1, then HIGH.
- Assert rst mid-dead-time → outputs 11 asynchronously, busy=0; after release, a full dead interval precedes the new level.
